load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Initiator side of the core data bus. Accepts one load/store request at a time from the
//   pipeline and drives the bus (rw/len/addr/write) with registered outputs. Holds the access
//   for BUS_WAIT extra cycles, then samples read/exception and returns extended load data.
//   Sits between the execute stage and data_bus.
// PARAMETERS
//   BUS_WAIT   0   extra cycles to hold each access before sampling bus_read/bus_exception (0..15)
// PORTS
//   clk            in   1   system clock, all state on rising edge
//   rst            in   1   synchronous, active-high reset
//   req_valid      in   1   pipeline request present
//   req_ready      out  1   unit can accept request (high only in IDLE)
//   req_store      in   1   1=store, 0=load
//   req_size       in   2   0=byte, 1=half, 2=word, 3=illegal
//   req_unsigned   in   1   loads: 1=zero-extend, 0=sign-extend
//   req_addr       in   32  byte address
//   req_wdata      in   32  store data, right-justified
//   rsp_valid      out  1   one-cycle completion pulse
//   rsp_rdata      out  32  extended load data (0 for stores/faults)
//   rsp_fault      out  1   bus_exception sampled high for this access
//   rsp_misalign   out  1   misaligned/illegal-size request (trap build only)
//   bus_rw         out  1   1=write; high only in ACCESS/WAIT of a store
//   bus_len        out  2   copy of req_size (3 mapped to 2)
//   bus_addr       out  32  access address
//   bus_write      out  32  masked store data, right-justified
//   bus_read       in   32  bus read data, right-justified
//   bus_exception  in   1   bus access fault
// BEHAVIOUR
//   Reset: state=IDLE, bus_rw=0, bus_len=0, bus_addr=0, bus_write=0, rsp_valid=0,
//     rsp_rdata=0, rsp_fault=0, rsp_misalign=0. req_ready=1 in the cycle after reset.
//   FSM: IDLE, ACCESS, WAIT, RESP.
//   - IDLE: req_ready=1. On req_valid: latch request. Normal case -> ACCESS. Registered bus
//     outputs become valid in the first ACCESS cycle.
//   - ACCESS: if BUS_WAIT==0, sample bus_read/bus_exception -> RESP; else load wait_cnt=BUS_WAIT-1 -> WAIT.
//   - WAIT: decrement wait_cnt; at 0, sample -> RESP. Bus outputs stay stable throughout.
//   - RESP: rsp_valid=1 for exactly one cycle; bus_rw=0 in the same cycle; -> IDLE.
//   - Latency: request acceptance edge to rsp_valid = BUS_WAIT+2 cycles; then next request is accepted in IDLE.
//   bus_addr/bus_len/bus_write hold their last values in IDLE. Only bus_rw drops, so a
//     store never leaves rw=1 while the address changes (data_bus LED decode).
//   Store data masking: byte {24'b0,wdata[7:0]}; half {16'b0,wdata[15:0]}; word wdata.
//   Load data: byte/half taken from bus_read[7:0]/[15:0].
//     - req_unsigned=0: sign-extend from bit 7/15.
//     - req_unsigned=1: zero-extend.
//     - Word loads pass through unchanged.
//   rsp_fault=1 forces rsp_rdata=0. Stores always return rsp_rdata=0.
//   Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or req_size=3.
//   rst high in any state: next edge returns to IDLE with reset values. An in-flight
//     response is dropped (no rsp_valid).
//   req_valid outside IDLE is ignored (req_ready=0). Requests are never queued.
// CONFIGURATION
//   LSU_MISALIGN_TRAP_EN defined: a misaligned request makes no bus access (bus_rw stays 0)
//     and goes IDLE->RESP, so rsp_valid comes 1 cycle after acceptance.
//     The response has rsp_misalign=1, rsp_fault=0 and rsp_rdata=0.
//   Not defined: address low bits are cleared (half: [0], word: [1:0]), size 3 is treated
//     as word, and the access proceeds normally. rsp_misalign is tied 0.
// TESTING
//   1. BUS_WAIT=0, word store addr=0x1000_0004 wdata=0xDEADBEEF -> bus_rw=1 for 1 cycle, bus_len=2,
//      bus_write=0xDEADBEEF, rsp_valid 2 cycles after accept, rsp_rdata=0.
//   2. Byte load, signed, bus_read=0x0000_0080 -> rsp_rdata=0xFFFF_FF80.
//      Same load with req_unsigned=1 -> 0x0000_0080.
//   3. BUS_WAIT=3, half load, bus_exception=1 -> bus outputs stable 4 cycles, rsp_valid at
//      accept+5, rsp_fault=1, rsp_rdata=0.
//   4. Word load addr=0x...2: with LSU_MISALIGN_TRAP_EN -> no bus_rw, rsp_valid at accept+1,
//      rsp_misalign=1. Without it -> bus_addr=0x...0, normal completion.
//   5. rst asserted during WAIT of a store -> next cycle bus_rw=0, req_ready=1, no rsp_valid.
//   6. Back-to-back: store to LEDS then load -> second accepted in the cycle of the first rsp_valid;
//      bus_rw is never high while bus_addr changes.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for the core data bus.
// Requests are accepted only in IDLE; the bus access is held for BUS_WAIT extra
// cycles before bus_read/bus_exception are sampled, and the extended result is
// returned as a one-cycle rsp_valid pulse that coincides with the unit being
// ready again.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests skip the bus
// and respond with rsp_misalign=1 instead of being silently aligned).
module load_store_unit #(
    parameter int BUS_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        rsp_misalign,
    output logic        bus_rw,
    output logic [1:0]  bus_len,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write,
    input  logic [31:0] bus_read,
    input  logic        bus_exception
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_store;
    logic        r_unsigned;
    logic        r_trap;
    logic        r_excSample;
    logic [1:0]  r_len;
    logic [3:0]  r_waitCnt;
    logic [31:0] r_readSample;

    logic        w_trap;
    logic        w_sample;
    logic [1:0]  w_len;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_loadData;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = ((req_size == 2'd1) && req_addr[0]) ||
                    ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                    (req_size == 2'd3);
`else
    assign w_trap = 1'b0;
`endif

    assign req_ready = (r_state == S_IDLE);

    // Size 3 is treated as a word access; low address bits are dropped to align.
    assign w_len  = (req_size == 2'd3) ? 2'd2 : req_size;
    assign w_addr = (w_len == 2'd2) ? {req_addr[31:2], 2'b00} :
                    (w_len == 2'd1) ? {req_addr[31:1], 1'b0}  : req_addr;

    // The bus only ever sees the bytes that belong to the access size.
    assign w_wdata = (w_len == 2'd0) ? {24'b0, req_wdata[7:0]}  :
                     (w_len == 2'd1) ? {16'b0, req_wdata[15:0]} : req_wdata;

    // Sampling happens in the last cycle the access is held on the bus.
    assign w_sample = ((r_state == S_ACCESS) && (BUS_WAIT == 0)) ||
                      ((r_state == S_WAIT) && (r_waitCnt == 4'd0));

    // Extend the sampled read data according to the latched size and signedness.
    always_comb begin
        w_loadData = r_readSample;
        case (r_len)
            2'd0: w_loadData = r_unsigned ? {24'b0, r_readSample[7:0]}
                                          : {{24{r_readSample[7]}}, r_readSample[7:0]};
            2'd1: w_loadData = r_unsigned ? {16'b0, r_readSample[15:0]}
                                          : {{16{r_readSample[15]}}, r_readSample[15:0]};
            default: w_loadData = r_readSample;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state selection; trapped requests bypass the bus entirely.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (req_valid) w_nextState = w_trap ? S_RESP : S_ACCESS;
            S_ACCESS: w_nextState = w_sample ? S_RESP : S_WAIT;
            S_WAIT:   w_nextState = w_sample ? S_RESP : S_WAIT;
            S_RESP:   w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // Request latch, registered bus outputs, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_store      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_trap       <= 1'b0;
            r_excSample  <= 1'b0;
            r_len        <= 2'd0;
            r_waitCnt    <= 4'd0;
            r_readSample <= 32'd0;
            bus_rw       <= 1'b0;
            bus_len      <= 2'd0;
            bus_addr     <= 32'd0;
            bus_write    <= 32'd0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_fault    <= 1'b0;
            rsp_misalign <= 1'b0;
        end else begin
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_fault    <= 1'b0;
            rsp_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store    <= req_store;
                        r_unsigned <= req_unsigned;
                        r_len      <= w_len;
                        r_trap     <= w_trap;
                        if (!w_trap) begin
                            bus_rw    <= req_store;
                            bus_len   <= w_len;
                            bus_addr  <= w_addr;
                            bus_write <= w_wdata;
                        end
                    end
                end
                S_ACCESS, S_WAIT: begin
                    if (w_sample) begin
                        r_readSample <= bus_read;
                        r_excSample  <= bus_exception;
                        bus_rw       <= 1'b0;
                    end else if (r_state == S_ACCESS) begin
                        r_waitCnt <= 4'(BUS_WAIT - 1);
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                S_RESP: begin
                    rsp_valid    <= 1'b1;
                    rsp_misalign <= r_trap;
                    rsp_fault    <= !r_trap && r_excSample;
                    rsp_rdata    <= (r_trap || r_store || r_excSample) ? 32'd0 : w_loadData;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: two instances (BUS_WAIT=0 and BUS_WAIT=3) share one request
// stream. Expected responses are queued at acceptance and popped by a monitor
// whenever rsp_valid is seen; bus outputs and req_ready are checked every cycle
// against the transaction window the driver records.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        misalign;
        int          acc;
        int          lat;
    } exp_t;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid, reqStore, reqUnsigned, busException;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWdata, busRead;

    logic        ready0, rv0, fault0, mis0, rw0;
    logic [1:0]  len0;
    logic [31:0] rdata0, addr0, wr0;
    logic        ready3, rv3, fault3, mis3, rw3;
    logic [1:0]  len3;
    logic [31:0] rdata3, addr3, wr3;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;
    bit monActive  = 1'b0;

    exp_t q0[$];
    exp_t q3[$];
    exp_t monE0, monE3;

    bit          winValid = 1'b0;
    bit          winStore, winBus;
    int          winAcc, winLat0, winLat3;
    logic [31:0] expAddr  = 32'd0;
    logic [31:0] expWrite = 32'd0;
    logic [1:0]  expLen   = 2'd0;

    load_store_unit #(.BUS_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(ready0),
        .req_store(reqStore), .req_size(reqSize), .req_unsigned(reqUnsigned),
        .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rv0), .rsp_rdata(rdata0),
        .rsp_fault(fault0), .rsp_misalign(mis0), .bus_rw(rw0), .bus_len(len0),
        .bus_addr(addr0), .bus_write(wr0), .bus_read(busRead), .bus_exception(busException)
    );

    load_store_unit #(.BUS_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(ready3),
        .req_store(reqStore), .req_size(reqSize), .req_unsigned(reqUnsigned),
        .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rv3), .rsp_rdata(rdata3),
        .rsp_fault(fault3), .rsp_misalign(mis3), .bus_rw(rw3), .bus_len(len3),
        .bus_addr(addr3), .bus_write(wr3), .bus_read(busRead), .bus_exception(busException)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic checkBus(input string tag, input int bw, input int lat, input logic rw,
                            input logic ready, input logic [1:0] len, input logic [31:0] addr,
                            input logic [31:0] wr);
        logic inWin, expRw, expReady;
        inWin    = winValid && (cyc >= winAcc);
        expRw    = inWin && winStore && winBus && (cyc <= winAcc + bw);
        expReady = !(inWin && (cyc <= winAcc + lat - 1));
        checkOutput({tag, " bus_rw"},    32'(rw),    32'(expRw));
        checkOutput({tag, " req_ready"}, 32'(ready), 32'(expReady));
        checkOutput({tag, " bus_len"},   32'(len),   32'(expLen));
        checkOutput({tag, " bus_addr"},  addr,       expAddr);
        checkOutput({tag, " bus_write"}, wr,         expWrite);
    endtask

    task automatic checkRsp(input string tag, input exp_t e, input logic [31:0] rd,
                            input logic f, input logic m);
        checkOutput({tag, " rsp_rdata"},    rd,              e.rdata);
        checkOutput({tag, " rsp_fault"},    32'(f),          32'(e.fault));
        checkOutput({tag, " rsp_misalign"}, 32'(m),          32'(e.misalign));
        checkOutput({tag, " rsp_latency"},  32'(cyc - e.acc), 32'(e.lat));
    endtask

    // Monitor: per-cycle bus/ready checks and scoreboard pops on every response.
    always @(negedge clk) begin
        if (monActive) begin
            checkBus("d0", 0, winLat0, rw0, ready0, len0, addr0, wr0);
            checkBus("d3", 3, winLat3, rw3, ready3, len3, addr3, wr3);
            if (rv0) begin
                checkOutput("d0 rsp_expected", 32'(q0.size() > 0), 32'd1);
                if (q0.size() > 0) begin
                    monE0 = q0.pop_front();
                    checkRsp("d0", monE0, rdata0, fault0, mis0);
                end
            end
            if (rv3) begin
                checkOutput("d3 rsp_expected", 32'(q3.size() > 0), 32'd1);
                if (q3.size() > 0) begin
                    monE3 = q3.pop_front();
                    checkRsp("d3", monE3, rdata3, fault3, mis3);
                end
            end
        end
    end

    // Issue one request to both units, record the expected bus window and response.
    task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic un,
                                 input logic [31:0] ad, input logic [31:0] wd,
                                 input logic [31:0] rd, input logic ex,
                                 input bit junk, input bit doReset);
        int          waitCnt;
        int          effSize;
        logic        mis, trap;
        logic [63:0] m64;
        logic [31:0] mask, v, effAddr;
        exp_t        e;
        waitCnt = 0;
        @(negedge clk);
        while (!(ready0 && ready3) && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("issue_ready", 32'(ready0 && ready3), 32'd1);
        if (!(ready0 && ready3)) return;
        reqStore = st; reqSize = sz; reqUnsigned = un; reqAddr = ad; reqWdata = wd;
        busRead = rd; busException = ex; reqValid = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0;

        mis = ((sz == 2'd1) && ad[0]) || ((sz == 2'd2) && (ad[1:0] != 2'b00)) || (sz == 2'd3);
        trap    = mis && TRAP_EN;
        effSize = (sz == 2'd3) ? 2 : int'(sz);
        m64     = (64'd1 << (8 * (1 << effSize))) - 64'd1;
        mask    = m64[31:0];
        effAddr = ad & ~(32'((1 << effSize) - 1));
        v       = rd & mask;
        if (!un && effSize < 2 && ((v & ((mask >> 1) + 32'd1)) != 32'd0)) v = v | ~mask;

        winAcc   = cyc;
        winLat0  = trap ? 1 : 2;
        winLat3  = trap ? 1 : 5;
        winStore = st;
        winBus   = !trap;
        winValid = 1'b1;
        if (!trap) begin
            expAddr  = effAddr;
            expLen   = 2'(effSize);
            expWrite = wd & mask;
        end

        if (doReset) begin
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            winValid = 1'b0;
            expAddr = 32'd0; expLen = 2'd0; expWrite = 32'd0;
            @(negedge clk);
            checkOutput("reset_drop d0 rsp_valid", 32'(rv0), 32'd0);
            checkOutput("reset_drop d3 rsp_valid", 32'(rv3), 32'd0);
            checkOutput("reset_drop d3 bus_rw",    32'(rw3), 32'd0);
            return;
        end

        e.rdata    = (trap || st || ex) ? 32'd0 : v;
        e.fault    = !trap && ex;
        e.misalign = trap;
        e.acc      = winAcc;
        e.lat      = winLat0;
        q0.push_back(e);
        e.lat      = winLat3;
        q3.push_back(e);

        if (junk) begin
            @(negedge clk);
            reqStore = 1'($urandom); reqSize = 2'($urandom); reqAddr = $urandom;
            reqWdata = $urandom; reqValid = 1'b1;
            @(posedge clk);
            #1 reqValid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ad;
        rst = 1'b1; reqValid = 1'b0; reqStore = 1'b0; reqSize = 2'd0; reqUnsigned = 1'b0;
        reqAddr = 32'd0; reqWdata = 32'd0; busRead = 32'd0; busException = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset d0 rsp_valid", 32'(rv0), 32'd0);
        checkOutput("reset d3 rsp_valid", 32'(rv3), 32'd0);
        checkOutput("reset d0 bus_rw",    32'(rw0), 32'd0);
        checkOutput("reset d3 bus_addr",  addr3,    32'd0);
        checkOutput("reset d0 bus_write", wr0,      32'd0);
        checkOutput("reset d3 bus_len",   32'(len3), 32'd0);
        checkOutput("reset d0 rsp_rdata", rdata0,   32'd0);
        checkOutput("reset d3 rsp_fault", 32'(fault3), 32'd0);
        checkOutput("reset d0 rsp_misalign", 32'(mis0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        monActive = 1'b1;
        @(negedge clk);
        checkOutput("post_reset d0 req_ready", 32'(ready0), 32'd1);
        checkOutput("post_reset d3 req_ready", 32'(ready3), 32'd1);

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0080, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0080, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0,         32'h0000_9234, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h0000_0026, 32'h0,         32'h0000_9234, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000_0002, 32'h0,         32'hCAFE_BABE, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h1000_0013, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd3, 1'b0, 32'h1000_0009, 32'hA5A5_0F0F, 32'h0,         1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h1000_0008, 32'h55AA_55AA, 32'h0,         1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'hF000_0000, 32'h0000_00A5, 32'h0,         1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd2, 1'b1, 32'h0000_0100, 32'h0,         32'h8765_4321, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) ad = ad & ~32'h3;
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), ad, $urandom, $urandom,
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            if (q0.size() == 0 && q3.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("d0 queue_drained", 32'(q0.size()), 32'd0);
        checkOutput("d3 queue_drained", 32'(q3.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
